cla_seq_add_ctrl: RTL and testbench

CLA_SEQ_ADD_CTRL -- requirements
Module: cla_seq_add_ctrl

---
 rtl/cla_seq_add_ctrl.sv | 128 ++++++++++++
 tb/tb_cla_seq_add_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_add_ctrl.sv
// rtl/cla_seq_add_ctrl.sv - byte-serial add/sub controller driving an external 8-bit CLA
// One operand byte per CALC cycle, LSB first, with the carry chained through a register.
module cla_seq_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  input  logic                  abort,
  output logic [7:0]            cla_a,
  output logic [7:0]            cla_b,
  output logic                  cla_cin,
  input  logic [7:0]            cla_sum,
  input  logic                  cla_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  zero,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [W-1:0]   a_reg, b_reg;
  logic           sub_reg, cin_reg;
  logic [W-1:0]   result_r;
  logic           cout_r, ovf_r, zero_r;
  logic           last;
  logic [7:0]     a_byte, b_byte;
  logic [W-1:0]   result_nxt;

  assign last   = (idx == IW'(NBYTES - 1));
  assign a_byte = a_reg[{idx, 3'b000} +: 8];
  assign b_byte = b_reg[{idx, 3'b000} +: 8];

  always_comb begin
    result_nxt = result_r;
    result_nxt[{idx, 3'b000} +: 8] = cla_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    cla_a     = 8'h00;
    cla_b     = 8'h00;
    cla_cin   = 1'b0;
    if (state == CALC) begin
      cla_a   = a_byte;
      cla_b   = sub_reg ? ~b_byte : b_byte;
      // Subtraction is a + ~b + 1, so the first byte always gets a carry-in of 1.
      cla_cin = (idx == '0) ? (sub_reg | cin_reg) : carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      cin_reg  <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_reg   <= a;
        b_reg   <= b;
        sub_reg <= sub;
        cin_reg <= cin;
        idx     <= '0;
        carry   <= 1'b0;
      end else if (state == CALC && !abort) begin
        result_r <= result_nxt;
        carry    <= cla_cout;
        idx      <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout_r <= cla_cout;
          ovf_r  <= (cla_a[7] == cla_b[7]) && (cla_sum[7] != cla_a[7]);
          zero_r <= (result_nxt == '0);
        end
      end
    end
  end

  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb/tb_cla_seq_add_ctrl.sv - self-checking bench for cla_seq_add_ctrl
// Expected values come from plain 32-bit arithmetic on the operands.
module tb_cla_seq_add_ctrl;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   cla_a, cla_b, cla_sum;
  logic         cla_cin, cla_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout, ovf, zero, busy;

  int total = 0;
  int bad = 0;

  logic [W-1:0] er;
  logic         ec, eo, ez;

  cla_seq_add_ctrl #(.NBYTES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .abort(abort),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy)
  );

  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {8'b0, cla_cin};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms, input logic mc);
    logic [W:0] t;
    if (ms) begin
      er = ma - mb;
      ec = (ma >= mb);
      eo = (ma[W-1] != mb[W-1]) && (er[W-1] != ma[W-1]);
    end else begin
      t  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      er = t[W-1:0];
      ec = t[W];
      eo = (ma[W-1] == mb[W-1]) && (er[W-1] != ma[W-1]);
    end
    ez = (er == '0);
  endtask

  task automatic drive(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms, input logic mc);
    a = ma; b = mb; sub = ms; cin = mc;
    model(ma, mb, ms, mc);
    in_valid = 1'b1;
  endtask

  task automatic accept_chk;
    logic [7:0] eb;
    tick;
    in_valid = 1'b0;
    eb = sub ? ~b[7:0] : b[7:0];
    chk("busy_after_accept", busy, 1'b1);
    chk("in_ready_calc", in_ready, 1'b0);
    chk("cla_a_idx0", cla_a, a[7:0]);
    chk("cla_b_idx0", cla_b, eb);
    chk("cla_cin_idx0", cla_cin, sub ? 1'b1 : cin);
    // Operands must already be latched: disturb the inputs for the rest of the op.
    a = $urandom; b = $urandom; sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
  endtask

  task automatic wait_chk;
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("latency", cyc, N);
    chk("result", result, er);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    chk("zero", zero, ez);
    chk("cla_a_done", cla_a, 8'h00);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("idle_after_release", in_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] old_r;
    logic         old_c, old_o, old_z, seen;

    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_cla", {cla_a, cla_b, cla_cin}, '0);
    chk("rst_flags", {cout, ovf, zero}, 3'b000);
    #4;
    rst_n = 1'b1;

    drive(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    accept_chk; wait_chk; release_out;
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    accept_chk; wait_chk; release_out;
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    accept_chk; wait_chk; release_out;
    drive(32'h00000005, 32'h00000007, 1'b1, 1'b0);
    accept_chk; wait_chk; release_out;
    drive(32'h80000000, 32'h00000001, 1'b1, 1'b1);
    accept_chk; wait_chk; release_out;

    // Hold the result in DONE while a new request waits.
    drive(32'h12345678, 32'h0000FFFF, 1'b0, 1'b1);
    accept_chk; wait_chk;
    old_r = er; old_c = ec; old_o = eo; old_z = ez;
    drive(32'h00010000, 32'h00000001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_result", result, old_r);
      chk("stall_flags", {cout, ovf, zero}, {old_c, old_o, old_z});
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("no_accept_on_release", busy, 1'b0);
    chk("release_valid_low", out_valid, 1'b0);
    accept_chk; wait_chk; release_out;

    // Abort while byte index 2 is being computed.
    drive(32'hA5A5_1234, 32'h0101_0101, 1'b0, 1'b0);
    accept_chk;
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_partial", result[15:0], er[15:0]);
    seen = out_valid;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | out_valid;
    end
    chk("abort_no_valid", seen, 1'b0);

    // Asynchronous reset in the middle of CALC.
    drive(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1);
    accept_chk;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cla", {cla_a, cla_b, cla_cin}, '0);
    chk("arst_flags", {out_valid, cout, ovf, zero}, 4'b0000);
    chk("arst_in_ready", in_ready, 1'b1);
    drive(32'h0000_00FE, 32'h0000_0003, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    chk("rel_in_ready", in_ready, 1'b1);
    accept_chk; wait_chk; release_out;

    for (int k = 0; k < 16; k++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (k % 4 == 0) begin
        a[W-1:W-8] = 8'h7F;
        b[W-1:W-8] = 8'h7F;
        model(a, b, sub, cin);
      end
      accept_chk; wait_chk;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick;
      release_out;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
